// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: master FSM states and counter/pointer width helpers.
package wb_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, ERROR} wb_master_state_t;

   // Bits needed to hold the values 0..n (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Bits needed to index 0..depth-1 (at least one bit).
   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// Small in-order FIFO holding one tag per issued request until it is answered.
module wb_tag_fifo
   import wb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic [CW-1:0]               count;
   logic                        wr_en, rd_en;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A push into a full FIFO is only legal when a pop frees the slot on the same edge.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (rd_en) rd_ptr <= next_ptr(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_pipelined_master.sv
// Wishbone B4 pipelined master: valid/ready command side, stall-aware strobes,
// in-order responses and a no-ack timeout that flushes outstanding requests as errors.
module wb_pipelined_master
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 10,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                  wb_clock_i,
   input  logic                  wb_reset_n_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_data_i,
   input  logic                  cmd_last_i,
   output logic                  rsp_valid_o,
   output logic                  rsp_we_o,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  rsp_err_o,
   output logic                  busy_o,
   output logic [ADDR_WIDTH-1:0] wb_addr_o,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic                  wb_we_o,
   output logic                  wb_cycle_o,
   output logic                  wb_strobe_o,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   input  logic                  wb_stall_i,
   input  logic                  wb_ack_i
);

   localparam int CW = cnt_width(MAX_OUTSTANDING);
   localparam int TW = cnt_width(TIMEOUT_CYCLES);

   wb_master_state_t state, state_nxt;

   logic [1:0]    rst_sync;
   logic          rst_n;
   logic [CW-1:0] outstanding;
   logic [TW-1:0] tmo_cnt;
   logic          issue, ack, accept, room, tmo_near, tmo_fire, drain_done;
   logic          fifo_empty, fifo_full, fifo_dout, err_pop;

   // Reset asserts asynchronously and is released on a clock edge.
   always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
      if (!wb_reset_n_i) rst_sync <= '0;
      else               rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign issue   = wb_strobe_o && !wb_stall_i;
   assign ack     = wb_ack_i && (outstanding != '0) && (state != ERROR);
   assign err_pop = (state == ERROR) && !fifo_empty;

   // A strobe issuing this edge still counts as outstanding; acks are not credited early.
   assign room = ({1'b0, outstanding} + {{CW{1'b0}}, wb_strobe_o}) < (CW + 1)'(MAX_OUTSTANDING);

   assign tmo_near = (TIMEOUT_CYCLES != 0) && (state != ERROR) && (outstanding != '0) &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign tmo_fire = tmo_near && !ack && !issue;

   assign cmd_ready_o = rst_n && ((state == IDLE) || (state == ACTIVE)) &&
                        (!wb_strobe_o || !wb_stall_i) && room && !tmo_near;
   assign accept      = cmd_valid_i && cmd_ready_o;

   assign drain_done = !wb_strobe_o &&
                       ((outstanding == '0) || ((outstanding == CW'(1)) && ack));

   assign busy_o = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = cmd_last_i ? DRAIN : ACTIVE;
         ACTIVE:  if (accept && cmd_last_i) state_nxt = DRAIN;
         DRAIN:   if (drain_done) state_nxt = IDLE;
         ERROR:   if (fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (tmo_fire) state_nxt = ERROR;
   end

   always_ff @(posedge wb_clock_i or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge wb_clock_i or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         tmo_cnt     <= '0;
      end else begin
         if (err_pop)             outstanding <= outstanding - CW'(1);
         else if (issue && !ack)  outstanding <= outstanding + CW'(1);
         else if (!issue && ack)  outstanding <= outstanding - CW'(1);

         if ((outstanding == '0) || ack || issue || tmo_fire || (state == ERROR))
            tmo_cnt <= '0;
         else if (TIMEOUT_CYCLES != 0)
            tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   // Bus-side request registers; a pending unissued strobe is dropped on timeout.
   always_ff @(posedge wb_clock_i or negedge rst_n) begin
      if (!rst_n) begin
         wb_cycle_o  <= 1'b0;
         wb_strobe_o <= 1'b0;
         wb_addr_o   <= '0;
         wb_data_o   <= '0;
         wb_we_o     <= 1'b0;
      end else if (tmo_fire) begin
         wb_cycle_o  <= 1'b0;
         wb_strobe_o <= 1'b0;
      end else if (accept) begin
         wb_cycle_o  <= 1'b1;
         wb_strobe_o <= 1'b1;
         wb_addr_o   <= cmd_addr_i;
         wb_data_o   <= cmd_data_i;
         wb_we_o     <= cmd_we_i;
      end else begin
         if (issue) wb_strobe_o <= 1'b0;
         if ((state == DRAIN) && drain_done) wb_cycle_o <= 1'b0;
      end
   end

   always_ff @(posedge wb_clock_i or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_o <= 1'b0;
         rsp_we_o    <= 1'b0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         rsp_valid_o <= ack || err_pop;
         rsp_we_o    <= (ack || err_pop) && fifo_dout;
         rsp_data_o  <= ack ? wb_data_i : '0;
         rsp_err_o   <= err_pop;
      end
   end

   wb_tag_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tags (
      .clk   (wb_clock_i),
      .rst_n (rst_n),
      .push  (issue),
      .pop   (ack || err_pop),
      .din   (wb_we_o),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // The ready rule must make it impossible to issue beyond the tracking capacity.
   assert property (@(posedge wb_clock_i) disable iff (!rst_n)
      !(issue && !ack && (outstanding == CW'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_wb_pipelined_master.sv
// Directed bench for wb_pipelined_master: per-cycle vector table plus hand-written
// timeout and mid-cycle reset sequences.
module tb_wb_pipelined_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_we, cmd_last;
   logic [9:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       rsp_valid, rsp_we, rsp_err, busy;
   logic [7:0] rsp_data;
   logic [9:0] wb_addr;
   logic [7:0] wb_dout, wb_din;
   logic       wb_we, wb_cyc, wb_stb, wb_stall, wb_ack;

   int total = 0;
   int bad   = 0;
   int cur_row = -1;

   always #5 clk = ~clk;

   wb_pipelined_master #(
      .DATA_WIDTH(8), .ADDR_WIDTH(10), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .wb_clock_i   (clk),
      .wb_reset_n_i (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_we_i     (cmd_we),
      .cmd_addr_i   (cmd_addr),
      .cmd_data_i   (cmd_data),
      .cmd_last_i   (cmd_last),
      .rsp_valid_o  (rsp_valid),
      .rsp_we_o     (rsp_we),
      .rsp_data_o   (rsp_data),
      .rsp_err_o    (rsp_err),
      .busy_o       (busy),
      .wb_addr_o    (wb_addr),
      .wb_data_o    (wb_dout),
      .wb_we_o      (wb_we),
      .wb_cycle_o   (wb_cyc),
      .wb_strobe_o  (wb_stb),
      .wb_data_i    (wb_din),
      .wb_stall_i   (wb_stall),
      .wb_ack_i     (wb_ack)
   );

   // One clock cycle: inputs held during the cycle, ready checked before the edge,
   // registered outputs checked just after it.
   typedef struct packed {
      logic       v, we, last;
      logic [9:0] a;
      logic [7:0] d;
      logic       stall, ack;
      logic [7:0] rd;
      logic       x_rdy, x_stb, x_cyc;
      logic [9:0] x_adr;
      logic       x_rv, x_rwe;
      logic [7:0] x_rdata;
      logic       x_busy;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic v, we, last, input logic [9:0] a,
                               input logic [7:0] d, input logic stall, ack,
                               input logic [7:0] rd, input logic xr, xs, xc,
                               input logic [9:0] xa, input logic xv, xw,
                               input logic [7:0] xd, input logic xb);
      vec_t r;
      r.v = v; r.we = we; r.last = last; r.a = a; r.d = d; r.stall = stall;
      r.ack = ack; r.rd = rd; r.x_rdy = xr; r.x_stb = xs; r.x_cyc = xc;
      r.x_adr = xa; r.x_rv = xv; r.x_rwe = xw; r.x_rdata = xd; r.x_busy = xb;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s row=%0d t=%0t got=%h expected=%h", nm, cur_row, $time, got, exp);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_we = 0; cmd_last = 0; cmd_addr = '0; cmd_data = '0;
      wb_stall = 0; wb_ack = 0; wb_din = '0;
   endtask

   task automatic run_row(input int i);
      vec_t r;
      r = tv[i];
      cur_row = i;
      cmd_valid = r.v; cmd_we = r.we; cmd_last = r.last; cmd_addr = r.a; cmd_data = r.d;
      wb_stall = r.stall; wb_ack = r.ack; wb_din = r.rd;
      #1;
      chk("cmd_ready", 32'(cmd_ready), 32'(r.x_rdy));
      @(posedge clk); #1;
      chk("wb_strobe", 32'(wb_stb), 32'(r.x_stb));
      chk("wb_cycle", 32'(wb_cyc), 32'(r.x_cyc));
      if (r.x_stb) chk("wb_addr", 32'(wb_addr), 32'(r.x_adr));
      if (r.x_stb && r.v && r.x_rdy) begin
         chk("wb_we", 32'(wb_we), 32'(r.we));
         chk("wb_data", 32'(wb_dout), 32'(r.d));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(r.x_rv));
      if (r.x_rv) begin
         chk("rsp_we", 32'(rsp_we), 32'(r.x_rwe));
         chk("rsp_data", 32'(rsp_data), 32'(r.x_rdata));
         chk("rsp_err", 32'(rsp_err), 32'h0);
      end
      chk("busy", 32'(busy), 32'(r.x_busy));
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i < hi; i++) run_row(i);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_cyc"}, 32'(wb_cyc), 0);
      chk({nm, "_stb"}, 32'(wb_stb), 0);
      chk({nm, "_addr"}, 32'(wb_addr), 0);
      chk({nm, "_wdata"}, 32'(wb_dout), 0);
      chk({nm, "_we"}, 32'(wb_we), 0);
      chk({nm, "_rv"}, 32'(rsp_valid), 0);
      chk({nm, "_rdata"}, 32'(rsp_data), 0);
      chk({nm, "_rerr"}, 32'(rsp_err), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_ready"}, 32'(cmd_ready), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int s_a, s_b, s_c, s_d, s_e, s_t, s_r, s_f, s_end;

      // single write 0x3A5 <- 0x5C, ack two cycles after issue
      s_a = tv.size();
      tv.push_back(mk(1,1,1,10'h3A5,8'h5C,0,0,8'h00, 1,1,1,10'h3A5,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'h77, 0,0,0,10'h000,1,1,8'h77,0));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 1,0,0,10'h000,0,0,8'h00,0));
      // four back-to-back reads, acked in order
      s_b = tv.size();
      tv.push_back(mk(1,0,0,10'h010,8'h00,0,0,8'h00, 1,1,1,10'h010,0,0,8'h00,1));
      tv.push_back(mk(1,0,0,10'h011,8'h00,0,0,8'h00, 1,1,1,10'h011,0,0,8'h00,1));
      tv.push_back(mk(1,0,0,10'h012,8'h00,0,0,8'h00, 1,1,1,10'h012,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h013,8'h00,0,0,8'h00, 1,1,1,10'h013,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hA0, 0,0,1,10'h000,1,0,8'hA0,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hA1, 0,0,1,10'h000,1,0,8'hA1,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hA2, 0,0,1,10'h000,1,0,8'hA2,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hA3, 0,0,0,10'h000,1,0,8'hA3,0));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 1,0,0,10'h000,0,0,8'h00,0));
      // stall held three cycles on the second request
      s_c = tv.size();
      tv.push_back(mk(1,0,0,10'h010,8'h00,0,0,8'h00, 1,1,1,10'h010,0,0,8'h00,1));
      tv.push_back(mk(1,0,0,10'h011,8'h00,0,0,8'h00, 1,1,1,10'h011,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h012,8'h00,1,0,8'h00, 0,1,1,10'h011,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h012,8'h00,1,0,8'h00, 0,1,1,10'h011,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h012,8'h00,1,0,8'h00, 0,1,1,10'h011,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h012,8'h00,0,0,8'h00, 1,1,1,10'h012,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hB1, 0,0,1,10'h000,1,0,8'hB1,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hB2, 0,0,1,10'h000,1,0,8'hB2,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hB3, 0,0,0,10'h000,1,0,8'hB3,0));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 1,0,0,10'h000,0,0,8'h00,0));
      // stray ack in IDLE, then ack coinciding with an issue
      s_d = tv.size();
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'h55, 1,0,0,10'h000,0,0,8'h00,0));
      tv.push_back(mk(1,0,0,10'h020,8'h00,0,0,8'h00, 1,1,1,10'h020,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h021,8'h00,0,0,8'h00, 1,1,1,10'h021,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hC0, 0,0,1,10'h000,1,0,8'hC0,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hC1, 0,0,0,10'h000,1,0,8'hC1,0));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 1,0,0,10'h000,0,0,8'h00,0));
      // outstanding limit: fifth command waits until an ack frees a slot
      s_e = tv.size();
      tv.push_back(mk(1,0,0,10'h050,8'h00,0,0,8'h00, 1,1,1,10'h050,0,0,8'h00,1));
      tv.push_back(mk(1,0,0,10'h051,8'h00,0,0,8'h00, 1,1,1,10'h051,0,0,8'h00,1));
      tv.push_back(mk(1,0,0,10'h052,8'h00,0,0,8'h00, 1,1,1,10'h052,0,0,8'h00,1));
      tv.push_back(mk(1,0,0,10'h053,8'h00,0,0,8'h00, 1,1,1,10'h053,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h054,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h054,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h054,8'h00,0,1,8'hD0, 0,0,1,10'h000,1,0,8'hD0,1));
      tv.push_back(mk(1,0,1,10'h054,8'h00,0,0,8'h00, 1,1,1,10'h054,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hD1, 0,0,1,10'h000,1,0,8'hD1,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hD2, 0,0,1,10'h000,1,0,8'hD2,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hD3, 0,0,1,10'h000,1,0,8'hD3,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hD4, 0,0,0,10'h000,1,0,8'hD4,0));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 1,0,0,10'h000,0,0,8'h00,0));
      // timeout setup: two reads issued, never acked
      s_t = tv.size();
      tv.push_back(mk(1,0,0,10'h030,8'h00,0,0,8'h00, 1,1,1,10'h030,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h031,8'h00,0,0,8'h00, 1,1,1,10'h031,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      // reset setup: three reads outstanding
      s_r = tv.size();
      tv.push_back(mk(1,0,0,10'h040,8'h00,0,0,8'h00, 1,1,1,10'h040,0,0,8'h00,1));
      tv.push_back(mk(1,0,0,10'h041,8'h00,0,0,8'h00, 1,1,1,10'h041,0,0,8'h00,1));
      tv.push_back(mk(1,0,1,10'h042,8'h00,0,0,8'h00, 1,1,1,10'h042,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      // normal read after reset
      s_f = tv.size();
      tv.push_back(mk(1,0,1,10'h060,8'h00,0,0,8'h00, 1,1,1,10'h060,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 0,0,1,10'h000,0,0,8'h00,1));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,1,8'hE7, 0,0,0,10'h000,1,0,8'hE7,0));
      tv.push_back(mk(0,0,0,10'h000,8'h00,0,0,8'h00, 1,0,0,10'h000,0,0,8'h00,0));
      s_end = tv.size();

      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1;
      repeat (3) @(posedge clk);
      #1;

      run_rows(s_a, s_b);
      run_rows(s_b, s_c);
      run_rows(s_c, s_d);
      run_rows(s_d, s_e);
      run_rows(s_e, s_t);

      // Last issue lands on the final setup edge; the 16th idle edge after it aborts.
      run_rows(s_t, s_r);
      cur_row = -2;
      idle_inputs();
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         chk("tmo_wait_cyc", 32'(wb_cyc), 1);
         chk("tmo_wait_rv", 32'(rsp_valid), 0);
      end
      @(posedge clk); #1;
      chk("tmo_err_cyc", 32'(wb_cyc), 0);
      chk("tmo_err_stb", 32'(wb_stb), 0);
      chk("tmo_err_busy", 32'(busy), 1);
      chk("tmo_err_ready", 32'(cmd_ready), 0);
      chk("tmo_err_rv0", 32'(rsp_valid), 0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("tmo_rsp_valid", 32'(rsp_valid), 1);
         chk("tmo_rsp_err", 32'(rsp_err), 1);
         chk("tmo_rsp_data", 32'(rsp_data), 0);
         chk("tmo_rsp_we", 32'(rsp_we), 0);
         chk("tmo_rsp_cyc", 32'(wb_cyc), 0);
      end
      @(posedge clk); #1;
      chk("tmo_done_rv", 32'(rsp_valid), 0);
      chk("tmo_done_busy", 32'(busy), 0);
      chk("tmo_done_ready", 32'(cmd_ready), 1);

      // Reset pulled mid-cycle with three requests outstanding.
      run_rows(s_r, s_f);
      cur_row = -3;
      #2;
      rst_n = 0;
      #1;
      chk_all_zero("midrst");
      wb_ack = 1; wb_din = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("midrst_hold_rv", 32'(rsp_valid), 0);
         chk("midrst_hold_cyc", 32'(wb_cyc), 0);
      end
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("postrst_rv", 32'(rsp_valid), 0);
         chk("postrst_cyc", 32'(wb_cyc), 0);
      end
      idle_inputs();
      run_rows(s_f, s_end);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
